// File: rtl/cmos_pkg.sv
// Shared types and default geometry for the OV7670 capture front end.
package cmos_pkg;

  localparam int unsigned H_PIXELS_DEF = 320;
  localparam int unsigned V_LINES_DEF  = 240;
  localparam int unsigned FRAME_PIXELS = H_PIXELS_DEF * V_LINES_DEF;
  localparam int unsigned ADDR_W       = $clog2(FRAME_PIXELS);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    WAIT_VS_FALL = 2'd1,
    ACTIVE       = 2'd2
  } capture_state_t;

  typedef logic [11:0] rgb444_t;

  function automatic rgb444_t pack_rgb444(input logic [3:0] red, input logic [7:0] green_blue);
    return {red, green_blue};
  endfunction

endpackage

// File: rtl/cmos_sync_edge.sv
// N-bit multi-stage synchroniser with per-bit rise/fall detection on the
// synchronised output; all bits share the same delay so edges stay aligned.
module cmos_sync_edge #(
  parameter int unsigned WIDTH  = 1,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  logic [WIDTH-1:0] stage_r [STAGES];
  logic [WIDTH-1:0] prev_r;

  // Synchroniser chain plus one extra flop holding the previous synchronised value.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < int'(STAGES); i++) begin
        stage_r[i] <= '0;
      end
      prev_r <= '0;
    end else begin
      stage_r[0] <= din;
      for (int i = 1; i < int'(STAGES); i++) begin
        stage_r[i] <= stage_r[i-1];
      end
      prev_r <= stage_r[STAGES-1];
    end
  end

  assign dout = stage_r[STAGES-1];
  assign rise = dout & ~prev_r;
  assign fall = ~dout & prev_r;

endmodule

// File: rtl/cmos_pixel_capture.sv
// OV7670 pin capture: syncs sensor pins, pairs bytes into RGB444 pixels, emits windowed writes.
// Build option: TEST_PATTERN_EN replaces sensor data with a {col,row,col} pattern.
module cmos_pixel_capture
  import cmos_pkg::*;
#(
  parameter int unsigned H_PIXELS    = H_PIXELS_DEF,
  parameter int unsigned V_LINES     = V_LINES_DEF,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                                clk_i,
  input  logic                                reset_i,
  input  logic                                pclk_cmos_i,
  input  logic                                vsync_cmos_i,
  input  logic                                href_cmos_i,
  input  logic [7:0]                          pixel_data_cmos_i,
  input  logic                                capture_en_i,
  output logic                                pixel_valid_o,
  output rgb444_t                             pixel_data_o,
  output logic [$clog2(H_PIXELS*V_LINES)-1:0] pixel_address_o,
  output logic                                frame_done_o,
  output logic                                frame_error_o
);

  localparam int unsigned ADDR_BITS = $clog2(H_PIXELS * V_LINES);
  localparam int unsigned CNT_BITS  = ADDR_BITS + 1;
  localparam int unsigned COL_BITS  = $clog2(H_PIXELS + 1);
  localparam int unsigned ROW_BITS  = $clog2(V_LINES + 1);

  logic pclk_s, pclk_rise_s, pclk_fall_s;
  logic vsync_s, vsync_rise_s, vsync_fall_s;
  logic href_s, href_rise_s, href_fall_s;
  logic [7:0] data_s, data_rise_s, data_fall_s;

  cmos_sync_edge #(.WIDTH(1), .STAGES(SYNC_STAGES)) u_sync_pclk (
    .clk_i(clk_i), .reset_i(reset_i), .din(pclk_cmos_i),
    .dout(pclk_s), .rise(pclk_rise_s), .fall(pclk_fall_s));
  cmos_sync_edge #(.WIDTH(1), .STAGES(SYNC_STAGES)) u_sync_vsync (
    .clk_i(clk_i), .reset_i(reset_i), .din(vsync_cmos_i),
    .dout(vsync_s), .rise(vsync_rise_s), .fall(vsync_fall_s));
  cmos_sync_edge #(.WIDTH(1), .STAGES(SYNC_STAGES)) u_sync_href (
    .clk_i(clk_i), .reset_i(reset_i), .din(href_cmos_i),
    .dout(href_s), .rise(href_rise_s), .fall(href_fall_s));
  cmos_sync_edge #(.WIDTH(8), .STAGES(SYNC_STAGES)) u_sync_data (
    .clk_i(clk_i), .reset_i(reset_i), .din(pixel_data_cmos_i),
    .dout(data_s), .rise(data_rise_s), .fall(data_fall_s));

  logic unused_edges_s;
  assign unused_edges_s = ^{pclk_s, pclk_fall_s, vsync_s, href_rise_s, data_rise_s, data_fall_s};

  capture_state_t        state_r, state_next_s;
  logic [COL_BITS-1:0]   col_r;
  logic [ROW_BITS-1:0]   row_r;
  logic [ADDR_BITS-1:0]  next_addr_r;
  logic [CNT_BITS-1:0]   count_r, cnt_next_s;
  logic                  phase_r, odd_err_r, done_pend_r, err_pend_r;
  logic [3:0]            red_r;
  logic                  sample_s, pixel_done_s, in_window_s, accept_s;
  logic                  frame_start_s, frame_end_s;
  rgb444_t               pixel_word_s;

  assign sample_s      = (state_r == ACTIVE) && pclk_rise_s && href_s;
  assign pixel_done_s  = sample_s && phase_r;
  assign in_window_s   = (col_r < COL_BITS'(H_PIXELS)) && (row_r < ROW_BITS'(V_LINES));
  assign accept_s      = pixel_done_s && in_window_s;
  assign frame_start_s = (state_r == WAIT_VS_FALL) && vsync_fall_s;
  assign frame_end_s   = (state_r == ACTIVE) && vsync_rise_s;
  // Clipped pixels still count, so an over-long line shows up as a frame error.
  assign cnt_next_s    = (pixel_done_s && (count_r != {CNT_BITS{1'b1}})) ?
                         count_r + CNT_BITS'(1'b1) : count_r;

`ifdef TEST_PATTERN_EN
  logic [8:0] pat_col_s;
  logic [7:0] pat_row_s;
  logic       unused_pattern_s;
  assign pat_col_s        = 9'(col_r);
  assign pat_row_s        = 8'(row_r);
  assign pixel_word_s     = {pat_col_s[8:5], pat_row_s[7:4], pat_col_s[3:0]};
  assign unused_pattern_s = ^{red_r, data_s};
`else
  assign pixel_word_s = pack_rgb444(red_r, data_s);
`endif

  // Capture state register.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic: frames are bracketed by VSYNC pulses, enable checked only at the boundary.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (capture_en_i && vsync_rise_s) state_next_s = WAIT_VS_FALL;
        else                              state_next_s = IDLE;
      end
      WAIT_VS_FALL: begin
        if (vsync_fall_s) state_next_s = ACTIVE;
        else              state_next_s = WAIT_VS_FALL;
      end
      ACTIVE: begin
        if (vsync_rise_s) begin
          if (capture_en_i) state_next_s = WAIT_VS_FALL;
          else              state_next_s = IDLE;
        end else begin
          state_next_s = ACTIVE;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // Byte pairing, window counters, address generation and frame status.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      col_r           <= '0;
      row_r           <= '0;
      next_addr_r     <= '0;
      count_r         <= '0;
      phase_r         <= 1'b0;
      odd_err_r       <= 1'b0;
      red_r           <= 4'h0;
      done_pend_r     <= 1'b0;
      err_pend_r      <= 1'b0;
      pixel_valid_o   <= 1'b0;
      pixel_data_o    <= 12'h000;
      pixel_address_o <= '0;
      frame_done_o    <= 1'b0;
      frame_error_o   <= 1'b0;
    end else begin
      pixel_valid_o <= accept_s;
      done_pend_r   <= frame_end_s;
      frame_done_o  <= done_pend_r;
      if (accept_s) begin
        pixel_data_o    <= pixel_word_s;
        pixel_address_o <= next_addr_r;
        next_addr_r     <= next_addr_r + ADDR_BITS'(1'b1);
      end
      if (frame_start_s) begin
        col_r       <= '0;
        row_r       <= '0;
        next_addr_r <= '0;
        count_r     <= '0;
        phase_r     <= 1'b0;
        odd_err_r   <= 1'b0;
      end else if (state_r == ACTIVE) begin
        count_r <= cnt_next_s;
        if (href_fall_s) begin
          if (row_r < ROW_BITS'(V_LINES)) row_r <= row_r + ROW_BITS'(1'b1);
          col_r   <= '0;
          phase_r <= 1'b0;
          if (phase_r) odd_err_r <= 1'b1;
        end else if (sample_s) begin
          if (!phase_r) begin
            red_r   <= data_s[3:0];
            phase_r <= 1'b1;
          end else begin
            phase_r <= 1'b0;
            if (col_r < COL_BITS'(H_PIXELS)) col_r <= col_r + COL_BITS'(1'b1);
          end
        end
      end
      if (frame_end_s) begin
        err_pend_r <= (cnt_next_s != CNT_BITS'(H_PIXELS * V_LINES)) || odd_err_r;
      end
      if (done_pend_r) begin
        frame_error_o <= err_pend_r;
      end
    end
  end

endmodule

// File: tb/tb_cmos_pixel_capture.sv
// Directed bench for cmos_pixel_capture on a reduced 8x4 window at clk:PCLK = 4:1.
module tb_cmos_pixel_capture;

  localparam int H  = 8;
  localparam int V  = 4;
  localparam int AW = $clog2(H * V);

  logic          clk = 1'b0;
  logic          reset_i, pclk, vsync, href, capture_en;
  logic [7:0]    data;
  logic          pixel_valid_o, frame_done_o, frame_error_o;
  logic [11:0]   pixel_data_o;
  logic [AW-1:0] pixel_address_o;

  always #5 clk = ~clk;

  cmos_pixel_capture #(.H_PIXELS(H), .V_LINES(V), .SYNC_STAGES(2)) dut (
    .clk_i(clk), .reset_i(reset_i), .pclk_cmos_i(pclk), .vsync_cmos_i(vsync),
    .href_cmos_i(href), .pixel_data_cmos_i(data), .capture_en_i(capture_en),
    .pixel_valid_o(pixel_valid_o), .pixel_data_o(pixel_data_o),
    .pixel_address_o(pixel_address_o), .frame_done_o(frame_done_o),
    .frame_error_o(frame_error_o));

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Strobe monitor, sampled on the inactive edge.
  int          got_addr[$];
  logic [11:0] got_data[$];
  int          done_cnt = 0;
  always @(negedge clk) begin
    if (pixel_valid_o) begin
      got_addr.push_back(int'(pixel_address_o));
      got_data.push_back(pixel_data_o);
    end
    if (frame_done_o) done_cnt++;
  end

  int          exp_addr[$];
  logic [11:0] exp_data[$];

  function automatic logic [11:0] exp_pix(input int col, input int row);
`ifdef TEST_PATTERN_EN
    logic [8:0] c;
    logic [7:0] r;
    c = 9'(col);
    r = 8'(row);
    return {c[8:5], r[7:4], c[3:0]};
`else
    return 12'hABC;
`endif
  endfunction

  task automatic expect_line(input int first_addr, input int npix, input int row);
    for (int c = 0; c < npix; c++) begin
      exp_addr.push_back(first_addr + c);
      exp_data.push_back(exp_pix(c, row));
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    data = b;
    pclk = 1'b0;
    wait_clk(2);
    pclk = 1'b1;
    wait_clk(2);
  endtask

  task automatic send_line(input int npix, input bit odd);
    href = 1'b1;
    for (int p = 0; p < npix; p++) begin
      send_byte(8'h0A);
      send_byte(8'hBC);
    end
    if (odd) send_byte(8'h0A);
    href = 1'b0;
    wait_clk(6);
  endtask

  task automatic vsync_pulse();
    vsync = 1'b1;
    wait_clk(8);
    vsync = 1'b0;
    wait_clk(8);
  endtask

  task automatic compare_results(input string tag, input int exp_done);
    int n;
    check_eq($sformatf("%s_count", tag), 32'(got_addr.size()), 32'(exp_addr.size()));
    n = (got_addr.size() < exp_addr.size()) ? got_addr.size() : exp_addr.size();
    for (int i = 0; i < n; i++) begin
      check_eq($sformatf("%s_addr%0d", tag, i), 32'(got_addr[i]), 32'(exp_addr[i]));
      check_eq($sformatf("%s_data%0d", tag, i), 32'(got_data[i]), 32'(exp_data[i]));
    end
    check_eq($sformatf("%s_done", tag), 32'(done_cnt), 32'(exp_done));
    got_addr.delete();
    got_data.delete();
    exp_addr.delete();
    exp_data.delete();
    done_cnt = 0;
  endtask

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, "_valid"}, 32'(pixel_valid_o), 32'd0);
    check_eq({tag, "_data"},  32'(pixel_data_o),  32'd0);
    check_eq({tag, "_addr"},  32'(pixel_address_o), 32'd0);
    check_eq({tag, "_done"},  32'(frame_done_o),  32'd0);
    check_eq({tag, "_error"}, 32'(frame_error_o), 32'd0);
  endtask

  initial begin
    reset_i = 1'b1; pclk = 1'b0; vsync = 1'b0; href = 1'b0;
    capture_en = 1'b0; data = 8'h00;
    wait_clk(4);
    check_outputs_zero("reset");
    reset_i = 1'b0;
    wait_clk(2);

    // Clean frame.
    capture_en = 1'b1;
    vsync_pulse();
    for (int r = 0; r < V; r++) begin
      send_line(H, 1'b0);
      expect_line(r * H, H, r);
    end
    vsync_pulse();
    compare_results("clean", 1);
    check_eq("clean_error", 32'(frame_error_o), 32'd0);

    // Row 0 one pixel too long: extra pixel clipped, row 1 starts at H.
    send_line(H + 1, 1'b0);
    expect_line(0, H, 0);
    for (int r = 1; r < V; r++) begin
      send_line(H, 1'b0);
      expect_line(r * H, H, r);
    end
    vsync_pulse();
    check_eq("long_row1_first_addr", 32'(got_addr.size() > H ? got_addr[H] : -1), 32'(H));
    compare_results("long", 1);
    check_eq("long_error", 32'(frame_error_o), 32'd1);

    // Row 0 ends after three bytes: one pixel, odd byte dropped.
    send_line(1, 1'b1);
    expect_line(0, 1, 0);
    for (int r = 1; r < V; r++) begin
      send_line(H, 1'b0);
      expect_line(1 + (r - 1) * H, H, r);
    end
    vsync_pulse();
    compare_results("odd", 1);
    check_eq("odd_error", 32'(frame_error_o), 32'd1);

    // Clean frame closed with capture disabled: error clears, capture stops.
    for (int r = 0; r < V; r++) begin
      send_line(H, 1'b0);
      expect_line(r * H, H, r);
    end
    capture_en = 1'b0;
    vsync_pulse();
    compare_results("clean2", 1);
    check_eq("clean2_error", 32'(frame_error_o), 32'd0);

    // Disabled through a VSYNC pulse, enabled mid-frame: nothing until next frame.
    send_line(H, 1'b0);
    vsync_pulse();
    send_line(H, 1'b0);
    capture_en = 1'b1;
    send_line(H, 1'b0);
    compare_results("disabled", 0);

    // Reset mid-frame after 10 pixels, then restart from address 0.
    vsync_pulse();
    send_line(H, 1'b0);
    send_line(2, 1'b0);
    expect_line(0, H, 0);
    expect_line(H, 2, 1);
    check_eq("pre_reset_addr", 32'(pixel_address_o), 32'(H + 1));
    reset_i = 1'b1;
    wait_clk(1);
    check_outputs_zero("midreset");
    reset_i = 1'b0;
    wait_clk(2);
    send_line(H, 1'b0);
    vsync_pulse();
    send_line(H, 1'b0);
    expect_line(0, H, 0);
    compare_results("restart", 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
